l1_reg_serializer: RTL

- Read-side counterpart of the L1 byte-wise register splice.
- Captures a 192-bit L1 word (24 bytes) in one cycle and streams it out as bytes, lowest byte first, over a valid/ready handshake.
- Each byte carries its index, so a downstream byte-wide consumer can address it.
- Sits between the L1 accelerator result path and the 8-bit AHB/APB-side readback logic.

---
 rtl/l1_reg_serializer.sv | 90 +++++++++
 1 files changed

// File: rtl/l1_reg_serializer.sv
// Read-side serializer for the L1 wide register: captures a 192-bit word and
// streams it out lowest byte first, each byte tagged with its lane index.
module l1_reg_serializer #(
    parameter int NBYTES = 24,
    parameter int IDXW   = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [8*NBYTES-1:0]   din,
    input  logic [IDXW-1:0]       len,
    input  logic                  abort,
    output logic [7:0]            dout,
    output logic [IDXW-1:0]       dout_idx,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] NB  = IDXW'(NBYTES);
    localparam logic [IDXW-1:0] ONE = IDXW'(1);

    state_t                 state;
    state_t                 state_next;
    logic [8*NBYTES-1:0]    shadow;
    logic [IDXW-1:0]        last_idx;
    logic [IDXW-1:0]        eff_last;
    logic                   xfer;
    logic                   is_last;

    // A length of zero or anything beyond the word size means the whole word.
    assign eff_last = ((len == '0) || (len > NB)) ? (NB - ONE) : (len - ONE);

    assign xfer       = dout_valid && dout_ready;
    assign is_last    = (dout_idx == last_idx);
    assign dout_valid = (state == SEND);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load)           state_next = SEND;
            SEND: if (xfer && is_last) state_next = DONE;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // The shadow word shifts down one byte per transfer so the next byte to
    // present is always sitting in shadow[15:8].
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow   <= '0;
            dout     <= '0;
            dout_idx <= '0;
            last_idx <= '0;
        end else if (!abort) begin
            if ((state == IDLE) && load) begin
                shadow   <= din;
                dout     <= din[7:0];
                dout_idx <= '0;
                last_idx <= eff_last;
            end else if ((state == SEND) && xfer && !is_last) begin
                shadow   <= shadow >> 8;
                dout     <= shadow[15:8];
                dout_idx <= dout_idx + ONE;
            end
        end
    end

endmodule
